alu_uart_ctrl: RTL
==================

ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NB_DATA, 8, operand/result/byte width
- NB_OP, 6, opcode width, taken from the low bits of the third byte
- NB_TOUT, 16, width of the inter-byte timeout counter
- TOUT_TICKS, 16'd40000, i_tick count allowed between bytes of one frame
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- i_clk, in, 1, single clock, rising edge
- i_reset, in, 1, asynchronous active-low reset
- i_tick, in, 1, baud-rate oversampling tick, one i_clk wide
- i_rx_data, in, NB_DATA, received byte
- i_rx_valid, in, 1, one-cycle pulse; i_rx_data valid this cycle
- i_alu_result, in, NB_DATA, combinational ALU result
- i_tx_done, in, 1, one-cycle pulse; transmitter finished a byte
- o_data_a, out, NB_DATA, registered operand A to the ALU
- o_data_b, out, NB_DATA, registered operand B to the ALU
- o_op, out, NB_OP, registered opcode to the ALU
- o_tx_data, out, NB_DATA, byte to transmit
- o_tx_start, out, 1, one-cycle pulse; start the transmitter
- o_error, out, 1, one-cycle pulse; frame aborted by timeout
- o_busy, out, 1, high in any state other than WAIT_A

Function
REQ-003 The FSM SHALL be one-hot, with states WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
REQ-004 In WAIT_A, i_rx_valid=1 SHALL load o_data_a from i_rx_data and go to WAIT_B.
REQ-005 In WAIT_B, i_rx_valid=1 SHALL load o_data_b and go to WAIT_OP.
REQ-006 In WAIT_OP, i_rx_valid=1 SHALL load o_op from i_rx_data[NB_OP-1:0] and go to EXEC.
REQ-007 EXEC SHALL last exactly one cycle, latch i_alu_result into o_tx_data, and go to SEND.
REQ-008 SEND SHALL last exactly one cycle, drive o_tx_start=1, and go to WAIT_TX.
REQ-009 WAIT_TX SHALL hold until i_tx_done=1, then go to WAIT_A.
- Latency: third i_rx_valid to o_tx_start = 2 cycles.
REQ-010 i_rx_valid in EXEC, SEND or WAIT_TX SHALL be ignored: no register change, no error.
REQ-011 The timeout counter SHALL clear on every accepted byte and on entry to WAIT_A.
REQ-012 In WAIT_B or WAIT_OP, the timeout counter SHALL increment on each i_tick.
REQ-013 When the counter reaches TOUT_TICKS-1 with i_tick=1, the FSM SHALL go to WAIT_A, pulse o_error for one cycle, and clear the counter.
REQ-014 If i_rx_valid and the terminal i_tick coincide, the byte SHALL be accepted and the timeout SHALL NOT fire.
REQ-015 The counter SHALL hold at 0 in WAIT_A, EXEC, SEND and WAIT_TX; it SHALL never wrap.
REQ-016 o_data_a, o_data_b and o_op SHALL hold their values until overwritten by a new byte, including after a timeout.
REQ-017 o_tx_data SHALL change only in EXEC.
REQ-018 o_tx_start and o_error SHALL be registered, glitch-free, and never high in the same cycle.
REQ-019 i_tx_done outside WAIT_TX SHALL be ignored.

Reset
REQ-020 i_reset=0 SHALL, asynchronously, force state WAIT_A and set all of the following to 0: o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_error, o_busy, the timeout counter.
REQ-021 Reset asserted mid-frame or mid-transmit SHALL discard the frame; after release the block SHALL wait for a new operand A.
REQ-022 The first state update SHALL occur on the first i_clk rising edge after i_reset deasserts.

Verification
REQ-023 Normal frame: bytes 0x05, 0x03, 0x20, with ALU returning 0x08 -> o_data_a=0x05, o_data_b=0x03, o_op=0x20; o_tx_data=0x08 and o_tx_start one pulse 2 cycles after the third valid; after i_tx_done, o_busy=0.
REQ-024 Timeout: byte 0x11, then no byte for TOUT_TICKS ticks -> single o_error pulse, state WAIT_A, o_data_a still 0x11; next frame 0x01, 0x02, 0x20 completes normally.
REQ-025 Coincidence: second byte arrives on the terminal tick -> byte accepted, no o_error, state WAIT_OP.
REQ-026 Ignored inputs: extra i_rx_valid (0xFF) during WAIT_TX and stray i_tx_done in WAIT_A -> no register, state or output change.
REQ-027 Async reset asserted in WAIT_OP, between clock edges -> all outputs 0 immediately; frame 0xAA, 0x55, 0x21 after release completes with o_tx_start exactly once.
REQ-028 Back-to-back frames, the next first byte arriving 1 cycle after i_tx_done -> both frames produce correct results, with no byte lost.

Source files
------------

// File: rtl/alu_uart_ctrl.sv
// rtl/alu_uart_ctrl.sv - UART frame controller: collects A, B, opcode bytes, runs the ALU, sends the result
// Inter-byte timeout aborts a partial frame; operand registers keep their last values.
module alu_uart_ctrl #(
  parameter int                 NB_DATA    = 8,
  parameter int                 NB_OP      = 6,
  parameter int                 NB_TOUT    = 16,
  parameter logic [NB_TOUT-1:0] TOUT_TICKS = 16'd40000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_error,
  output logic               o_busy
);

  typedef enum logic [5:0] {
    WAIT_A  = 6'b000001,
    WAIT_B  = 6'b000010,
    WAIT_OP = 6'b000100,
    EXEC    = 6'b001000,
    SEND    = 6'b010000,
    WAIT_TX = 6'b100000
  } state_t;

  state_t               state_q, state_d;
  logic [NB_DATA-1:0]   data_a_q, data_a_d;
  logic [NB_DATA-1:0]   data_b_q, data_b_d;
  logic [NB_OP-1:0]     op_q, op_d;
  logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 error_q, error_d;
  logic [NB_TOUT-1:0]   tout_q, tout_d;
  logic                 tout_last;
  logic                 tout_fire;

  assign tout_last = (tout_q == (TOUT_TICKS - 1'b1));
  // A byte arriving on the terminal tick wins over the timeout.
  assign tout_fire = i_tick && tout_last && !i_rx_valid;

  always_comb begin
    state_d   = state_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    error_d   = 1'b0;
    tout_d    = '0;

    unique case (state_q)
      WAIT_A: begin
        if (i_rx_valid) begin
          data_a_d = i_rx_data;
          state_d  = WAIT_B;
        end
      end
      WAIT_B, WAIT_OP: begin
        if (i_rx_valid) begin
          if (state_q == WAIT_B) begin
            data_b_d = i_rx_data;
            state_d  = WAIT_OP;
          end else begin
            op_d    = i_rx_data[NB_OP-1:0];
            state_d = EXEC;
          end
        end else if (tout_fire) begin
          error_d = 1'b1;
          state_d = WAIT_A;
        end else if (i_tick) begin
          tout_d = tout_q + 1'b1;
        end else begin
          tout_d = tout_q;
        end
      end
      EXEC: begin
        tx_data_d = i_alu_result;
        state_d   = SEND;
      end
      SEND: begin
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          state_d = WAIT_A;
        end
      end
      default: begin
        state_d = WAIT_A;
      end
    endcase

    tx_start_d = (state_d == SEND);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= WAIT_A;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      error_q    <= 1'b0;
      tout_q     <= '0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      error_q    <= error_d;
      tout_q     <= tout_d;
    end
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_error    = error_q;
  assign o_busy     = (state_q != WAIT_A);

endmodule
